// File: rtl/ascon_arbiter_pkg.sv
// Shared configuration for the Ascon core arbiter: data widths, core mode
// encoding and the arbiter FSM state type.
package ascon_arbiter_pkg;

    localparam int CCW      = 32;
    localparam int CCWD8    = CCW / 8;
    localparam int NREQ_MAX = 4;

    localparam logic [3:0] M_NOP  = 4'd0;
    localparam logic [3:0] M_ENC  = 4'd1;
    localparam logic [3:0] M_DEC  = 4'd2;
    localparam logic [3:0] M_HASH = 4'd3;
    localparam logic [3:0] M_XOF  = 4'd4;

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        IDLE     = 3'd1,
        START    = 3'd2,
        BUSY     = 3'd3,
        FINISH   = 3'd4
    } arb_fsm_t;

endpackage

// File: rtl/ascon_arbiter_if.sv
// Client-side request channels (packed per requester) plus the single
// core-side channel. slave = arbiter view, master = clients and core view.
interface ascon_arbiter_if #(
    parameter int NREQ = 2
) ();
    import ascon_arbiter_pkg::*;

    // Every stream channel is a plain valid/ready pair: a word moves on a
    // rising clk edge where both valid and ready are high; the source holds
    // data stable while valid is high and ready is low.
    logic [NREQ-1:0][3:0]       req_mode;
    logic [NREQ-1:0]            req_start;
    logic [NREQ-1:0][CCW-1:0]   req_key;
    logic [NREQ-1:0]            req_key_valid;
    logic [NREQ-1:0]            req_key_ready;
    logic [NREQ-1:0][CCW-1:0]   req_bdi;
    logic [NREQ-1:0][CCWD8-1:0] req_bdi_valid;
    logic [NREQ-1:0]            req_bdi_ready;
    logic [NREQ-1:0][3:0]       req_bdi_type;
    logic [NREQ-1:0]            req_bdi_eot;
    logic [NREQ-1:0]            req_bdi_eoi;
    logic [NREQ-1:0][CCW-1:0]   req_bdo;
    logic [NREQ-1:0]            req_bdo_valid;
    logic [NREQ-1:0]            req_bdo_ready;
    logic [NREQ-1:0][3:0]       req_bdo_type;
    logic [NREQ-1:0]            req_bdo_eot;
    logic [NREQ-1:0]            req_bdo_eoo;
    logic [NREQ-1:0]            req_done;
    logic [NREQ-1:0]            req_auth;
    logic [NREQ-1:0]            req_auth_valid;

    logic [3:0]       core_mode;
    logic [CCW-1:0]   core_key;
    logic             core_key_valid;
    logic             core_key_ready;
    logic [CCW-1:0]   core_bdi;
    logic [CCWD8-1:0] core_bdi_valid;
    logic             core_bdi_ready;
    logic [3:0]       core_bdi_type;
    logic             core_bdi_eot;
    logic             core_bdi_eoi;
    logic [CCW-1:0]   core_bdo;
    logic             core_bdo_valid;
    logic             core_bdo_ready;
    logic [3:0]       core_bdo_type;
    logic             core_bdo_eot;
    logic             core_bdo_eoo;
    logic             core_auth;
    logic             core_auth_valid;
    logic             core_done;

    modport slave (
        input  req_mode, req_key, req_key_valid, req_bdi, req_bdi_valid,
               req_bdi_type, req_bdi_eot, req_bdi_eoi, req_bdo_ready, req_bdo_eoo,
        output req_start, req_key_ready, req_bdi_ready, req_bdo, req_bdo_valid,
               req_bdo_type, req_bdo_eot, req_done, req_auth, req_auth_valid,
        output core_mode, core_key, core_key_valid, core_bdi, core_bdi_valid,
               core_bdi_type, core_bdi_eot, core_bdi_eoi, core_bdo_ready, core_bdo_eoo,
        input  core_key_ready, core_bdi_ready, core_bdo, core_bdo_valid,
               core_bdo_type, core_bdo_eot, core_auth, core_auth_valid, core_done
    );

    modport master (
        output req_mode, req_key, req_key_valid, req_bdi, req_bdi_valid,
               req_bdi_type, req_bdi_eot, req_bdi_eoi, req_bdo_ready, req_bdo_eoo,
        input  req_start, req_key_ready, req_bdi_ready, req_bdo, req_bdo_valid,
               req_bdo_type, req_bdo_eot, req_done, req_auth, req_auth_valid,
        input  core_mode, core_key, core_key_valid, core_bdi, core_bdi_valid,
               core_bdi_type, core_bdi_eot, core_bdi_eoi, core_bdo_ready, core_bdo_eoo,
        output core_key_ready, core_bdi_ready, core_bdo, core_bdo_valid,
               core_bdo_type, core_bdo_eot, core_auth, core_auth_valid, core_done
    );

endinterface

// File: rtl/ascon_rr_pick.sv
// Rotating-priority encoder: returns the first set request at or after
// ptr_i+1 (wrapping at N), so the last owner has the lowest priority.
module ascon_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] scan;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        scan  = ptr_i;
        for (int k = 0; k < N; k++) begin
            scan = (scan == IW'(N - 1)) ? '0 : scan + 1'b1;
            if (!any_o && req_i[scan]) begin
                idx_o = scan;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ascon_arbiter.sv
// Job-granular round-robin arbiter sharing one ascon_core between NREQ
// clients; also bridges the system reset into the core's synchronous reset.
module ascon_arbiter
    import ascon_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ascon_arbiter_if.slave bus,
    output logic           core_rst,
    output arb_fsm_t       dbg_state_o
);

    localparam int IW = $clog2(NREQ);

    arb_fsm_t        state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [3:0]      mode_q, mode_d;
    logic            done_q;
    logic            complete;
    logic            active;
    logic [NREQ-1:0] req_any;
    logic [NREQ-1:0] auth_q, auth_valid_q;
    logic [1:0]      rst_sync_q;

    // Asserts with rst_n, releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b11;
        else        rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign core_rst = rst_sync_q[1];

    always_comb begin
        req_any = '0;
        for (int i = 0; i < NREQ; i++) req_any[i] = (bus.req_mode[i] != M_NOP);
    end

    ascon_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req_i (req_any),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // The core's done stays high between jobs; only its rising edge ends one.
    assign complete = bus.core_done & ~done_q;
    assign active   = (state_q == START) || (state_q == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RST_WAIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        case (state_q)
            RST_WAIT: if (!core_rst) state_d = IDLE;
            IDLE: begin
                if (pick_any) begin
                    state_d = START;
                    gnt_d   = pick_idx;
                    mode_d  = bus.req_mode[pick_idx];
                end
            end
            START:    state_d = BUSY;
            BUSY:     if (complete) state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q        <= '0;
            mode_q       <= M_NOP;
            rr_ptr_q     <= IW'(NREQ - 1);
            done_q       <= 1'b0;
            auth_q       <= '0;
            auth_valid_q <= '0;
        end else begin
            gnt_q  <= gnt_d;
            mode_q <= mode_d;
            done_q <= bus.core_done;
            if (state_q == START) begin
                auth_q[gnt_q]       <= 1'b0;
                auth_valid_q[gnt_q] <= 1'b0;
            end
            if (state_q == FINISH) begin
                rr_ptr_q <= gnt_q;
                if (mode_q == M_DEC) begin
                    auth_q[gnt_q]       <= bus.core_auth;
                    auth_valid_q[gnt_q] <= bus.core_auth_valid;
                end
            end
        end
    end

    always_comb begin
        bus.req_start      = '0;
        bus.req_done       = '0;
        bus.req_key_ready  = '0;
        bus.req_bdi_ready  = '0;
        bus.req_bdo        = '0;
        bus.req_bdo_valid  = '0;
        bus.req_bdo_type   = '0;
        bus.req_bdo_eot    = '0;
        bus.req_auth       = auth_q;
        bus.req_auth_valid = auth_valid_q;
        bus.core_mode      = M_NOP;
        bus.core_key       = '0;
        bus.core_key_valid = 1'b0;
        bus.core_bdi       = '0;
        bus.core_bdi_valid = '0;
        bus.core_bdi_type  = '0;
        bus.core_bdi_eot   = 1'b0;
        bus.core_bdi_eoi   = 1'b0;
        bus.core_bdo_ready = 1'b0;
        bus.core_bdo_eoo   = 1'b0;
        // key_valid is muxed in START too: the core picks key vs nonce load from it.
        if (active) begin
            bus.core_key                = bus.req_key[gnt_q];
            bus.core_key_valid          = bus.req_key_valid[gnt_q];
            bus.core_bdi                = bus.req_bdi[gnt_q];
            bus.core_bdi_valid          = bus.req_bdi_valid[gnt_q];
            bus.core_bdi_type           = bus.req_bdi_type[gnt_q];
            bus.core_bdi_eot            = bus.req_bdi_eot[gnt_q];
            bus.core_bdi_eoi            = bus.req_bdi_eoi[gnt_q];
            bus.core_bdo_ready          = bus.req_bdo_ready[gnt_q];
            bus.core_bdo_eoo            = bus.req_bdo_eoo[gnt_q];
            bus.req_key_ready[gnt_q]    = bus.core_key_ready;
            bus.req_bdi_ready[gnt_q]    = bus.core_bdi_ready;
            bus.req_bdo[gnt_q]          = bus.core_bdo;
            bus.req_bdo_valid[gnt_q]    = bus.core_bdo_valid;
            bus.req_bdo_type[gnt_q]     = bus.core_bdo_type;
            bus.req_bdo_eot[gnt_q]      = bus.core_bdo_eot;
        end
        if (state_q == START) begin
            bus.core_mode        = mode_q;
            bus.req_start[gnt_q] = 1'b1;
        end
        if (state_q == FINISH) bus.req_done[gnt_q] = 1'b1;
    end

    assign dbg_state_o = state_q;

endmodule

// File: doc/ascon_arbiter.md
# ascon_arbiter

Shares one `ascon_core` instance between `NREQ` requester ports. Arbitration is round-robin at job granularity: a granted requester owns the core from the mode strobe until the core's `done` rises. The block muxes all key/bdi/mode signals into the core and routes bdo/auth/done back to the owner. It also generates the core's active-high synchronous reset from the system asynchronous active-low reset. It sits between the host-side client interfaces and `ascon_core`.

## Interface
Parameters:
- `NREQ`, 2: number of requester ports (2..4).
- `CCW`, from config (32): data width; `CCWD8` = CCW/8.

Ports (client-side ports are packed arrays `[NREQ-1:0]` of the stated width):
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous active-low reset.
- Client side:
  - `req_mode`  in  NREQ×4  job request; nonzero = request. Encoding is the core mode encoding.
  - `req_start`  out  NREQ  1-cycle pulse when the job is issued to the core.
  - `req_key`, `req_key_valid`, `req_key_ready`  in/in/out  CCW/1/1  key stream.
  - `req_bdi`, `req_bdi_valid`, `req_bdi_ready`  in/in/out  CCW/CCWD8/1  input data.
  - `req_bdi_type`, `req_bdi_eot`, `req_bdi_eoi`  in  4/1/1  input data qualifiers.
  - `req_bdo`, `req_bdo_valid`, `req_bdo_ready`  out/out/in  CCW/1/1  output data.
  - `req_bdo_type`, `req_bdo_eot`, `req_bdo_eoo`  out/out/in  4/1/1  output qualifiers.
  - `req_done`  out  NREQ  1-cycle job-complete pulse.
  - `req_auth`, `req_auth_valid`  out  NREQ each  captured tag-verify result.
- Core side:
  - `core_rst`  out  1  active-high reset to the core.
  - `core_mode`  out  4.
  - `core_key*`, `core_bdi*`, `core_bdo*`, `core_auth`, `core_auth_valid`, `core_done`: mirrors of the client signals above, one channel, opposite direction.

## Operation
- FSM states: `RST_WAIT`, `IDLE`, `START`, `BUSY`, `FINISH`.
- `RST_WAIT`: entered on reset. Stays until `core_rst` is low, then goes to `IDLE`.
- `IDLE`: `core_mode`=0 and all client ready/valid outputs are 0.
  - If any `req_mode[i]!=0`, pick the first requesting index starting at `rr_ptr+1` (mod NREQ).
  - Register `gnt`, latch `mode_q=req_mode[gnt]`, go to `START`.
- `START` (1 cycle): `core_mode=mode_q`; `req_start[gnt]`=1; all channels muxed from `gnt`.
  - `core_key_valid` must be muxed in this cycle, because the core chooses LD_KEY or LD_NPUB from it.
  - Clear `req_auth_valid[gnt]` and `req_auth[gnt]`. Go to `BUSY`.
- `BUSY`: `core_mode`=0; channels muxed from `gnt`. Non-granted clients see ready=0 and bdo_valid=0.
  - Completion = `core_done & !done_q`, where `done_q` is `core_done` delayed one cycle. This edge detect is required because core `done` is sticky across jobs.
  - On completion go to `FINISH`.
- `FINISH` (1 cycle):
  - `req_done[gnt]`=1.
  - If `mode_q` is decrypt, latch `req_auth[gnt]=core_auth` and `req_auth_valid[gnt]=core_auth_valid`. The captured value holds until that requester's next `START`.
  - `rr_ptr<=gnt`; go to `IDLE`.
- `req_mode` is sampled only in `IDLE`. The client drops it after `req_start`; if still nonzero at the next `IDLE`, that is a new job.
- Reset bridge: `core_rst` asserts asynchronously with `rst_n` low and deasserts through a 2-flop synchronizer.

## Timing
- Reset values: FSM=`RST_WAIT`, `rr_ptr`=NREQ-1 (so index 0 wins first), `core_rst`=1, and every other output 0.
- Request to core start:
  - Request visible in IDLE at cycle t; `START` at t+1; the core leaves its IDLE at t+2.
- Completion to next grant:
  - `core_done` rises at c; `FINISH` at c+1 (`req_done`, auth capture); `IDLE` at c+2; next `START` at c+3.
- Mux paths are purely combinational: zero added latency on bdi/bdo/key handshakes in `START`/`BUSY`.
- Simultaneous requests: rotate priority. No requester waits more than NREQ-1 jobs.
- `rst_n` low mid-job: FSM returns to `RST_WAIT` asynchronously and the core is reset. No `req_done` is issued; auth registers clear.
- `rst_n` rising: `core_rst` falls 2 clk edges later; `IDLE` is reached on the following cycle.

## Structure
- Add to the shared config package: FSM enum `arb_fsm_t`, `NREQ_MAX`=4, and the M_DEC constant reuse.
- Sub-module `ascon_rr_pick`: combinational rotate-priority encoder. Inputs: request vector and pointer. Outputs: index and any.
- The 2-flop reset synchronizer stays inline.

## Test plan
- Reset: `rst_n` low → all outputs 0, `core_rst`=1. Release → `core_rst` falls after 2 edges; FSM reaches IDLE.
- Single job: client 0 starts an ENC job with 16B AD and 16B message → `core_mode` nonzero for exactly 1 cycle; output matches the Ascon-AEAD128 KAT; `req_done[0]` is a single pulse.
- Contention: clients 0 and 1 request in the same cycle, repeated 4 jobs → grant order 0,1,0,1. Non-owner always sees ready=0.
- Decrypt auth: client 1 DEC with correct tag → `req_auth[1]`=1, valid=1, held through a client 0 job. Corrupted tag → `req_auth[1]`=0.
- Sticky done: back-to-back jobs from client 0 → second `req_done` only after the second completion, never in the `START`/`BUSY` cycle where the old `done` is still high.
- Reset mid-job: `rst_n` low during BUSY of a HASH job → no `req_done`. After release, a new hash of the empty message yields the KAT digest.
